// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests, queues responses for decode.
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue drives decode combinationally.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_id_valid,
    input  logic        i_id_ready,
    output logic [31:0] o_id_instr,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_pcplus4
);
    localparam int               PTR_W   = $clog2(FQ_DEPTH);
    localparam int               CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [31:0]      NOP     = 32'h0000_0013;

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;
    state_t r_state, w_state_next;

    logic             r_started;
    logic [31:0]      r_pc;
    logic [31:0]      r_if_pc   [FQ_DEPTH];
    logic [31:0]      r_q_instr [FQ_DEPTH];
    logic [31:0]      r_q_pc    [FQ_DEPTH];
    logic [PTR_W-1:0] r_if_wr, r_if_rd, r_q_wr, r_q_rd;
    logic [CNT_W-1:0] r_outstanding, r_drop_cnt, r_count;

    logic             w_rsp, w_rsp_run, w_grant, w_q_push, w_q_pop;
    logic [CNT_W-1:0] w_slots, w_drop_new;

    // Responses with nothing outstanding are protocol errors and are ignored.
    assign w_rsp      = i_imem_rvalid && (r_outstanding != '0);
    assign w_rsp_run  = w_rsp && (r_state == ST_RUN) && !i_redirect;
    assign w_q_pop    = (r_count != '0) && i_id_ready;
    assign w_drop_new = r_outstanding - CNT_W'(w_rsp);
    // A decode pop this cycle frees a slot, which sustains one fetch per cycle.
    assign w_slots    = r_count + r_outstanding - CNT_W'(w_q_pop);
    assign w_grant    = o_imem_req && i_imem_gnt;
    assign o_imem_addr = r_pc;

`ifdef FETCH_BYPASS_EN
    logic w_byp;
    assign w_byp      = w_rsp_run && (r_count == '0);
    assign w_q_push   = w_rsp_run && !(w_byp && i_id_ready);
    assign o_id_valid = (r_count != '0) || w_byp;
    assign o_id_instr = w_byp ? i_imem_rdata : r_q_instr[r_q_rd];
    assign o_id_pc    = w_byp ? r_if_pc[r_if_rd] : r_q_pc[r_q_rd];
`else
    assign w_q_push   = w_rsp_run;
    assign o_id_valid = (r_count != '0);
    assign o_id_instr = r_q_instr[r_q_rd];
    assign o_id_pc    = r_q_pc[r_q_rd];
`endif
    assign o_id_pcplus4 = o_id_pc + 32'd4;

    always_ff @(posedge i_clk) begin
        if (!i_reset) r_state <= ST_RUN;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_imem_req   = r_started && (r_state == ST_RUN) && !i_redirect && (w_slots < DEPTH_C);
        if (i_redirect)
            w_state_next = (w_drop_new != '0) ? ST_DRAIN : ST_RUN;
        else if ((r_state == ST_DRAIN) && w_rsp && (r_drop_cnt == ONE_C))
            w_state_next = ST_RUN;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_started     <= 1'b0;
            r_pc          <= RESET_PC;
            r_if_wr       <= '0;
            r_if_rd       <= '0;
            r_q_wr        <= '0;
            r_q_rd        <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_started <= 1'b1;
            if (i_redirect) begin
                r_pc          <= i_redirect_pc & ~32'h3;
                r_if_wr       <= '0;
                r_if_rd       <= '0;
                r_q_wr        <= '0;
                r_q_rd        <= '0;
                r_count       <= '0;
                r_outstanding <= w_drop_new;
                r_drop_cnt    <= w_drop_new;
            end else if (r_state == ST_DRAIN) begin
                if (w_rsp) begin
                    r_outstanding <= r_outstanding - ONE_C;
                    r_drop_cnt    <= r_drop_cnt - ONE_C;
                end
            end else begin
                if (w_grant) begin
                    r_pc    <= r_pc + 32'd4;
                    r_if_wr <= r_if_wr + PTR_ONE;
                end
                if (w_rsp)    r_if_rd <= r_if_rd + PTR_ONE;
                if (w_q_push) r_q_wr  <= r_q_wr + PTR_ONE;
                if (w_q_pop)  r_q_rd  <= r_q_rd + PTR_ONE;
                r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(w_rsp);
                r_count       <= r_count + CNT_W'(w_q_push) - CNT_W'(w_q_pop);
            end
        end
    end

    // Storage is reset so the idle head reads as a NOP at RESET_PC.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_if_pc[i]   <= RESET_PC;
                r_q_instr[i] <= NOP;
                r_q_pc[i]    <= RESET_PC;
            end
        end else begin
            if (w_grant) r_if_pc[r_if_wr] <= r_pc;
            if (w_q_push) begin
                r_q_instr[r_q_wr] <= i_imem_rdata;
                r_q_pc[r_q_wr]    <= r_if_pc[r_if_rd];
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (default build): in-order memory model with configurable latency.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b1;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = '0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_id_valid;
    logic        i_id_ready = 1'b1;
    logic [31:0] o_id_instr, o_id_pc, o_id_pcplus4;

    fetch_unit dut (
        .i_clk(clk), .i_reset(i_reset),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
        .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_id_valid(o_id_valid), .i_id_ready(i_id_ready),
        .o_id_instr(o_id_instr), .o_id_pc(o_id_pc), .o_id_pcplus4(o_id_pcplus4)
    );

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    int          cyc = 0, lat = 1, gcount = 0, g0 = 0;
    logic [31:0] pend_a[$];
    int          pend_d[$];

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'h0050_0093;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, update the memory model, then apply inputs for the new cycle.
    task automatic tick(input logic rdy, input logic rd, input logic [31:0] rpc, input logic gn);
        logic g, r, rs, hs;
        logic [31:0] a, hpc, hins;
        g    = (o_imem_req === 1'b1) && (i_imem_gnt === 1'b1);
        a    = o_imem_addr;
        r    = i_imem_rvalid;
        rs   = i_reset;
        hs   = (o_id_valid === 1'b1) && i_id_ready;
        hpc  = o_id_pc;
        hins = o_id_instr;
        @(posedge clk);
        #1;
        if (!rs) begin
            pend_a.delete();
            pend_d.delete();
        end else begin
            if (hs) $display("[TB] cyc %0d decode pc=%h instr=%h", cyc, hpc, hins);
            if (r && pend_a.size() > 0) begin
                void'(pend_a.pop_front());
                void'(pend_d.pop_front());
            end
            if (g) begin
                pend_a.push_back(a);
                pend_d.push_back(cyc + lat);
                gcount++;
                $display("[TB] cyc %0d grant addr=%h", cyc, a);
            end
        end
        cyc++;
        i_imem_rvalid = (pend_a.size() > 0) && (pend_d[0] <= cyc);
        i_imem_rdata  = i_imem_rvalid ? memw(pend_a[0]) : 32'h0;
        i_id_ready    = rdy;
        i_redirect    = rd;
        i_redirect_pc = rpc;
        i_imem_gnt    = gn;
        #1;
    endtask

    task automatic do_reset(input int l, input logic full);
        lat = l;
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1);
            chk("rst_req", {31'b0, o_imem_req}, 32'd0);
            chk("rst_valid", {31'b0, o_id_valid}, 32'd0);
            if (full && i == 2) begin
                chk("rst_addr", o_imem_addr, 32'h0);
                chk("rst_instr", o_id_instr, 32'h0000_0013);
                chk("rst_pc", o_id_pc, 32'h0);
                chk("rst_pcplus4", o_id_pcplus4, 32'h4);
            end
        end
        i_reset = 1'b1;
        #1;
        chk("rel_req_low", {31'b0, o_imem_req}, 32'd0);
        g0 = gcount;
    endtask

    initial begin
        // Reset and straight-line fetch, 1-cycle memory
        do_reset(1, 1'b1);
        tick(1, 0, 0, 1);
        chk("c1_req", {31'b0, o_imem_req}, 32'd1);
        chk("c1_addr", o_imem_addr, 32'h0);
        tick(1, 0, 0, 1);
        chk("c2_addr", o_imem_addr, 32'h4);
        chk("c2_valid", {31'b0, o_id_valid}, 32'd0);
        tick(1, 0, 0, 1);
        chk("sl_valid0", {31'b0, o_id_valid}, 32'd1);
        chk("sl_pc0", o_id_pc, 32'h0);
        chk("sl_instr0", o_id_instr, 32'h0050_0093);
        chk("sl_p4_0", o_id_pcplus4, 32'h4);
        tick(1, 0, 0, 1);
        chk("sl_pc1", o_id_pc, 32'h4);
        chk("sl_p4_1", o_id_pcplus4, 32'h8);
        tick(1, 0, 0, 1);
        chk("sl_pc2", o_id_pc, 32'h8);
        chk("sl_instr2", o_id_instr, memw(32'h8));

        // Decode stall: two grants fill the queue, then requests stop
        do_reset(1, 1'b0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        chk("st_req_c3", {31'b0, o_imem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1);
            chk("st_req", {31'b0, o_imem_req}, 32'd0);
            chk("st_valid", {31'b0, o_id_valid}, 32'd1);
            chk("st_pc", o_id_pc, 32'h0);
            chk("st_instr", o_id_instr, memw(32'h0));
        end
        chk("st_grants", gcount - g0, 32'd2);
        tick(1, 0, 0, 1);
        chk("st_rel_pc0", o_id_pc, 32'h0);
        chk("st_rel_addr", o_imem_addr, 32'h8);
        chk("st_rel_req", {31'b0, o_imem_req}, 32'd1);
        tick(1, 0, 0, 1);
        chk("st_rel_pc1", o_id_pc, 32'h4);
        tick(1, 0, 0, 1);
        chk("st_rel_pc2", o_id_pc, 32'h8);
        chk("st_rel_p4_2", o_id_pcplus4, 32'hC);

        // Redirect with two outstanding, 3-cycle memory
        do_reset(3, 1'b0);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        tick(1, 1, 32'h0000_0102, 1);
        chk("dr_req_r", {31'b0, o_imem_req}, 32'd0);
        tick(1, 0, 0, 1);
        chk("dr_req_d1", {31'b0, o_imem_req}, 32'd0);
        chk("dr_valid_d1", {31'b0, o_id_valid}, 32'd0);
        tick(1, 0, 0, 1);
        chk("dr_req_d2", {31'b0, o_imem_req}, 32'd0);
        tick(1, 0, 0, 1);
        chk("dr_req_new", {31'b0, o_imem_req}, 32'd1);
        chk("dr_addr_new", o_imem_addr, 32'h100);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        chk("dr_valid_pre", {31'b0, o_id_valid}, 32'd0);
        tick(1, 0, 0, 1);
        chk("dr_valid", {31'b0, o_id_valid}, 32'd1);
        chk("dr_pc", o_id_pc, 32'h100);
        chk("dr_p4", o_id_pcplus4, 32'h104);
        chk("dr_instr", o_id_instr, memw(32'h100));

        // Redirect in the same cycle as the only outstanding response
        do_reset(2, 1'b0);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 0);
        chk("sc_req_nognt", {31'b0, o_imem_req}, 32'd1);
        chk("sc_addr_nognt", o_imem_addr, 32'h4);
        tick(1, 1, 32'h0000_0200, 0);
        chk("sc_req_r", {31'b0, o_imem_req}, 32'd0);
        tick(1, 0, 0, 1);
        chk("sc_req_next", {31'b0, o_imem_req}, 32'd1);
        chk("sc_addr_next", o_imem_addr, 32'h200);
        chk("sc_valid_next", {31'b0, o_id_valid}, 32'd0);
        tick(1, 0, 0, 1);
        tick(1, 0, 0, 1);
        chk("sc_valid_c6", {31'b0, o_id_valid}, 32'd0);
        tick(1, 0, 0, 1);
        chk("sc_pc", o_id_pc, 32'h200);

        // PC wrap, then redirect coinciding with a decode handshake
        do_reset(1, 1'b0);
        tick(1, 1, 32'hFFFF_FFFC, 1);
        chk("wr_req_r", {31'b0, o_imem_req}, 32'd0);
        tick(1, 0, 0, 1);
        chk("wr_addr0", o_imem_addr, 32'hFFFF_FFFC);
        tick(1, 0, 0, 1);
        chk("wr_addr1", o_imem_addr, 32'h0);
        tick(1, 0, 0, 1);
        chk("wr_pc0", o_id_pc, 32'hFFFF_FFFC);
        chk("wr_p4_0", o_id_pcplus4, 32'h0);
        chk("wr_instr0", o_id_instr, memw(32'hFFFF_FFFC));
        tick(1, 1, 32'h0000_0040, 1);
        chk("hr_valid", {31'b0, o_id_valid}, 32'd1);
        chk("hr_pc", o_id_pc, 32'h0);
        chk("hr_req", {31'b0, o_imem_req}, 32'd0);
        tick(1, 0, 0, 1);
        chk("hr_cleared", {31'b0, o_id_valid}, 32'd0);
        chk("hr_addr", o_imem_addr, 32'h40);
        chk("hr_req_next", {31'b0, o_imem_req}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
